// File: rtl/hazard_pkg.sv
// Shared hazard-control types: FSM states and execute-stage operand mux3 select codes.
package hazard_pkg;

    localparam int unsigned FWDW = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        ERR    = 2'd2
    } state_e;

    // Select codes shared with the datapath mux3 instances.
    localparam logic [FWDW-1:0] FWD_RF  = 2'b00;
    localparam logic [FWDW-1:0] FWD_WB  = 2'b01;
    localparam logic [FWDW-1:0] FWD_MEM = 2'b10;

endpackage

// File: rtl/fwd_predict.sv
// Decode-stage forward prediction for one execute operand; the result is registered by the parent.
module fwd_predict
    import hazard_pkg::*;
#(
    parameter int unsigned REGW = 5
) (
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rd_e,
    input  logic            reg_write_e,
    input  logic [REGW-1:0] rd_m,
    input  logic            reg_write_m,
    output logic [FWDW-1:0] sel_c
);

    // The EX producer will sit in MEM when this consumer reaches EX, so it wins over MEM.
    always_comb begin
        sel_c = FWD_RF;
        if (rs != '0) begin
            if (reg_write_e && (rd_e == rs)) begin
                sel_c = FWD_MEM;
            end else if (reg_write_m && (rd_m == rs)) begin
                sel_c = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Pipeline hazard controller: registered forward selects, load-use/branch stall-flush, memory-wait freeze FSM.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int unsigned REGW    = 5,
    parameter int unsigned CNTW    = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [REGW-1:0] rs1_d,
    input  logic [REGW-1:0] rs2_d,
    input  logic [REGW-1:0] rd_e,
    input  logic            reg_write_e,
    input  logic            load_e,
    input  logic [REGW-1:0] rd_m,
    input  logic            reg_write_m,
    input  logic            pc_src_e,
    input  logic            mem_busy,
    output logic [1:0]      fwd_a_e,
    output logic [1:0]      fwd_b_e,
    output logic            stall_f,
    output logic            stall_d,
    output logic            stall_e,
    output logic            stall_m,
    output logic            flush_d,
    output logic            flush_e,
    output logic            frozen,
    output logic            mem_err,
    output logic [CNTW-1:0] stall_cnt
);

    localparam int unsigned BUSYW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    state_e             state;
    state_e             state_nxt;
    logic [BUSYW-1:0]   busy_cnt;
    logic [FWDW-1:0]    fwd_a_c;
    logic [FWDW-1:0]    fwd_b_c;
    logic               lu_c;
    logic               hold_c;
    logic               any_stall_c;

    fwd_predict #(.REGW(REGW)) u_fwd_a (
        .rs          (rs1_d),
        .rd_e        (rd_e),
        .reg_write_e (reg_write_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .sel_c       (fwd_a_c)
    );

    fwd_predict #(.REGW(REGW)) u_fwd_b (
        .rs          (rs2_d),
        .rd_e        (rd_e),
        .reg_write_e (reg_write_e),
        .rd_m        (rd_m),
        .reg_write_m (reg_write_m),
        .sel_c       (fwd_b_c)
    );

    assign lu_c = load_e && (rd_e != '0) && ((rd_e == rs1_d) || (rd_e == rs2_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus stall/flush controls; memory wait or ERR beats branch flush, which beats load-use.
    always_comb begin
        state_nxt = state;
        hold_c    = 1'b0;
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_e   = 1'b0;
        stall_m   = 1'b0;
        flush_d   = 1'b0;
        flush_e   = 1'b0;

        case (state)
            RUN: begin
                if (mem_busy) begin
                    state_nxt = FREEZE;
                end
            end
            FREEZE: begin
                if (!mem_busy) begin
                    state_nxt = RUN;
                end else if (busy_cnt == BUSYW'(TIMEOUT)) begin
                    state_nxt = ERR;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        if ((state != RUN) || mem_busy) begin
            hold_c  = 1'b1;
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
        end else if (pc_src_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lu_c) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign any_stall_c = stall_f || stall_d || stall_e || stall_m;

    // Status flags track the state register so they are glitch-free flop outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen  <= 1'b0;
            mem_err <= 1'b0;
        end else begin
            frozen  <= (state_nxt == FREEZE);
            mem_err <= (state_nxt == ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_e <= FWD_RF;
            fwd_b_e <= FWD_RF;
        end else if (flush_e) begin
            fwd_a_e <= FWD_RF;
            fwd_b_e <= FWD_RF;
        end else if (!hold_c) begin
            fwd_a_e <= fwd_a_c;
            fwd_b_e <= fwd_b_c;
        end
    end

    // Consecutive-busy counter, saturating at TIMEOUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_cnt <= '0;
        end else if (!mem_busy) begin
            busy_cnt <= '0;
        end else if (busy_cnt != BUSYW'(TIMEOUT)) begin
            busy_cnt <= busy_cnt + BUSYW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (any_stall_c && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNTW'(1);
        end
    end

endmodule
